aes_inv_block: RTL and testbench

AES_INV_BLOCK -- requirements
Module: aes_inv_block

---
 rtl/aes_pkg.sv | 69 ++++++
 rtl/aes_inv_round.sv | 55 +++++
 rtl/aes_inv_block.sv | 119 +++++++++++
 tb/tb_aes_inv_block.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: byte substitution tables, round constants,
// state and FSM types, and GF(2^8) arithmetic helpers.
package aes_pkg;

  typedef logic [127:0] state_t;

  typedef enum logic [2:0] {IDLE, KEYEXP, ADDKEY, ROUND, DONE} fsm_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  // Round constants indexed by round number; padded to 16 so a 4-bit counter indexes safely.
  localparam logic [7:0] RCON [16] = '{
    8'h00,8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,
    8'h80,8'h1b,8'h36,8'h00,8'h00,8'h00,8'h00,8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> optional InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  state_t state_in,
  input  state_t round_key,
  input  logic   skip_mix,
  output state_t state_out
);

  logic [7:0] in_b [16];
  logic [7:0] rk_b [16];
  logic [7:0] sh_b [16];
  logic [7:0] ak_b [16];
  logic [7:0] mx_b [16];
  state_t     s_tmp;
  state_t     k_tmp;

  // Unpack bytes (byte 0 at MSB), run the round steps, repack.
  always_comb begin
    s_tmp = state_in;
    k_tmp = round_key;
    for (int unsigned i = 0; i < 16; i++) begin
      in_b[4'(i)] = s_tmp[127:120];
      rk_b[4'(i)] = k_tmp[127:120];
      s_tmp = s_tmp << 8;
      k_tmp = k_tmp << 8;
    end
    // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4].
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sh_b[4'(4*c + r)] = INV_SBOX[in_b[4'(4*((c + 4 - r) % 4) + r)]];
      end
    end
    for (int unsigned i = 0; i < 16; i++) begin
      ak_b[4'(i)] = sh_b[4'(i)] ^ rk_b[4'(i)];
    end
    for (int unsigned c = 0; c < 4; c++) begin
      mx_b[4'(4*c)]   = gf_mul(ak_b[4'(4*c)], 8'h0e) ^ gf_mul(ak_b[4'(4*c+1)], 8'h0b)
                      ^ gf_mul(ak_b[4'(4*c+2)], 8'h0d) ^ gf_mul(ak_b[4'(4*c+3)], 8'h09);
      mx_b[4'(4*c+1)] = gf_mul(ak_b[4'(4*c)], 8'h09) ^ gf_mul(ak_b[4'(4*c+1)], 8'h0e)
                      ^ gf_mul(ak_b[4'(4*c+2)], 8'h0b) ^ gf_mul(ak_b[4'(4*c+3)], 8'h0d);
      mx_b[4'(4*c+2)] = gf_mul(ak_b[4'(4*c)], 8'h0d) ^ gf_mul(ak_b[4'(4*c+1)], 8'h09)
                      ^ gf_mul(ak_b[4'(4*c+2)], 8'h0e) ^ gf_mul(ak_b[4'(4*c+3)], 8'h0b);
      mx_b[4'(4*c+3)] = gf_mul(ak_b[4'(4*c)], 8'h0b) ^ gf_mul(ak_b[4'(4*c+1)], 8'h0d)
                      ^ gf_mul(ak_b[4'(4*c+2)], 8'h09) ^ gf_mul(ak_b[4'(4*c+3)], 8'h0e);
    end
    state_out = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      state_out = {state_out[119:0], skip_mix ? ak_b[4'(i)] : mx_b[4'(i)]};
    end
  end

endmodule

// File: rtl/aes_inv_block.sv
// Iterative AES-128 inverse cipher, one round per clock. The key schedule is
// first run forward to rk10, then unwound one step per decryption round.
module aes_inv_block
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  fsm_t       state_q, state_d;
  logic [3:0] cnt_q;
  state_t     rk_q;
  state_t     st_q;
  state_t     dout_q;
  state_t     round_out;

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
  endfunction

  function automatic state_t key_fwd(input state_t rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = rk;
    w0 = w0 ^ sub_rot(w3) ^ {rc, 24'h0};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo key_fwd: recover the later words first, then w0 from the recovered w3.
  function automatic state_t key_inv(input state_t rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = rk;
    w3 = w3 ^ w2;
    w2 = w2 ^ w1;
    w1 = w1 ^ w0;
    w0 = w0 ^ sub_rot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  aes_inv_round u_round (
    .state_in  (st_q),
    .round_key (rk_q),
    .skip_mix  (cnt_q == 4'd0),
    .state_out (round_out)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)        state_d = KEYEXP;
      KEYEXP:  if (cnt_q == 4'd10)  state_d = ADDKEY;
      ADDKEY:                       state_d = ROUND;
      ROUND:   if (cnt_q == 4'd0)   state_d = DONE;
      DONE:    if (out_ready)       state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    data_out  = dout_q;
  end

  // Datapath: key schedule, round state, counter and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rk_q   <= '0;
      st_q   <= '0;
      dout_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          rk_q  <= key;
          st_q  <= data_in;
          cnt_q <= 4'd1;
        end
        KEYEXP: begin
          rk_q  <= key_fwd(rk_q, RCON[cnt_q]);
          cnt_q <= cnt_q + 4'd1;
        end
        ADDKEY: begin
          st_q  <= st_q ^ rk_q;
          rk_q  <= key_inv(rk_q, RCON[10]);
          cnt_q <= 4'd9;
        end
        ROUND: begin
          if (cnt_q != 4'd0) begin
            st_q  <= round_out;
            rk_q  <= key_inv(rk_q, RCON[cnt_q]);
            cnt_q <= cnt_q - 4'd1;
          end else begin
            dout_q <= round_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_block.sv
// Scoreboard bench for aes_inv_block: the driver pushes expected plaintext
// and accept cycle; the monitor pops on each output handshake.
module tb_aes_inv_block;
  import aes_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   in_valid;
  logic   in_ready;
  state_t key;
  state_t data_in;
  logic   out_valid;
  logic   out_ready;
  state_t data_out;

  always #5 clk = ~clk;

  aes_inv_block dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key       (key),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  localparam state_t K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam state_t C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam state_t P1 = 128'h00112233445566778899aabbccddeeff;
  localparam state_t K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam state_t C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam state_t P2 = 128'h3243f6a8885a308d313198a2e0370734;

  typedef struct {
    state_t      pt;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int unsigned rise_cyc = 0;
  logic        prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference forward key schedule step and AES-128 encryption.
  function automatic state_t key_step(input state_t rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = rk;
    t  = {w3[23:0], w3[31:24]};
    t  = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic state_t encrypt(input state_t k, input state_t p);
    logic [7:0] s [16];
    logic [7:0] u [16];
    logic [7:0] a0, a1, a2, a3;
    state_t rk, v;
    rk = k;
    v  = p ^ k;
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) begin
        s[4'(i)] = SBOX[v[127:120]];
        v = v << 8;
      end
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          u[4'(4*c + rr)] = s[4'(4*((c + rr) % 4) + rr)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = u[4'(4*c)]; a1 = u[4'(4*c+1)]; a2 = u[4'(4*c+2)]; a3 = u[4'(4*c+3)];
          u[4'(4*c)]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
          u[4'(4*c+1)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
          u[4'(4*c+2)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
          u[4'(4*c+3)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
      end
      rk = key_step(rk, RCON[4'(r)]);
      v  = '0;
      for (int i = 0; i < 16; i++) v = {v[119:0], u[4'(i)]};
      v = v ^ rk;
    end
    return v;
  endfunction

  // Monitor: record out_valid rise, compare on each output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !prev_ov) rise_cyc = cyc;
    prev_ov = out_valid;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 128'd1, 128'd0);
      end else begin
        e = sb.pop_front();
        check("data_out", data_out, e.pt);
        check("latency", 128'(rise_cyc - e.acc), 128'd21);
      end
    end
  end

  // Offer a pair at a falling edge, hold until accepted, then push the expectation.
  task automatic issue(input state_t k, input state_t c, input state_t p);
    exp_t e;
    int   n;
    @(negedge clk);
    key      = k;
    data_in  = c;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 128'd0, 128'd1);
      in_valid = 1'b0;
    end else begin
      e.pt  = p;
      e.acc = cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 128'(sb.size()), 128'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int     n;
    int     seen;
    state_t hold;
    state_t rk, rp;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    key       = '0;
    data_in   = '0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_data_out", data_out, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", 128'(in_ready), 128'd1);

    // FIPS-197 vectors
    issue(K1, C1, P1);
    drain();
    issue(K2, C2, P2);
    drain();

    // Output back-pressure: hold out_ready low for 10 cycles after out_valid
    out_ready = 1'b0;
    issue(K2, C2, P2);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall_out_valid_seen", 128'(out_valid), 128'd1);
    hold = data_out;
    check("stall_first_data", hold, P2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_data_stable", data_out, hold);
      check("stall_in_ready", 128'(in_ready), 128'd0);
      check("stall_out_valid", 128'(out_valid), 128'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 check("handshake_clears_valid", 128'(out_valid), 128'd0);
    drain();

    // in_valid pulsed while rounds are running must be ignored
    issue(K1, C1, P1);
    repeat (13) @(negedge clk);
    key      = K2;
    data_in  = C2;
    in_valid = 1'b1;
    check("busy_in_ready", 128'(in_ready), 128'd0);
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_phantom_output", 128'(seen), 128'd0);

    // Reset asserted before edge 12 after accept abandons the block
    issue(K1, C1, P1);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midreset_out_valid", 128'(out_valid), 128'd0);
    check("midreset_data_out", data_out, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midreset_no_output", 128'(seen), 128'd0);
    check("midreset_data_zero", data_out, 128'd0);
    issue(K1, C1, P1);
    drain();

    // Back-to-back random pairs encrypted by the reference model
    for (int i = 0; i < 1000; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      issue(rk, encrypt(rk, rp), rp);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
